// File: rtl/data_store_buffer.sv
// Posted-write buffer between the pipeline data port and the AXI bridge data port.
// Stores are acked one cycle after acceptance and drained in order; loads are
// forwarded only once every buffered and in-flight store has completed.
module data_store_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OUT_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  // pipeline side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // bridge side
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OutW = $clog2(OUT_MAX + 1);

  logic [1:0]      r_fifo_size  [DEPTH];
  logic [31:0]     r_fifo_addr  [DEPTH];
  logic [3:0]      r_fifo_wstrb [DEPTH];
  logic [31:0]     r_fifo_wdata [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic [OutW-1:0] r_wr_out;
  logic            r_rd_busy;
  logic            r_ack_pend;

  logic w_store_acc;
  logic w_drain;
  logic w_pop;
  logic w_load_fwd;
  logic w_load_acc;
  logic w_rd_done;
  logic w_wr_done;

  // Handshake decisions; all decisions use registered occupancy, so a full
  // buffer that pops this cycle still refuses a store this cycle.
  always_comb begin
    w_store_acc = ~reset & data_req & data_wr & (r_cnt < CntW'(DEPTH)) & ~r_rd_busy;
    w_drain     = ~reset & (r_cnt != '0) & ~r_rd_busy & (r_wr_out < OutW'(OUT_MAX));
    w_load_fwd  = ~reset & data_req & ~data_wr & (r_cnt == '0) & (r_wr_out == '0) &
                  ~r_rd_busy & ~r_ack_pend;
    w_pop       = w_drain & m_addr_ok;
    w_load_acc  = w_load_fwd & m_addr_ok;
    w_rd_done   = ~reset & r_rd_busy & m_data_ok;
    // A response with nothing outstanding is ignored.
    w_wr_done   = ~reset & m_data_ok & (r_wr_out != '0);
  end

  // Bridge request mux (drain has priority) and pipeline responses
  always_comb begin
    m_req        = w_drain | w_load_fwd;
    m_wr         = w_drain;
    m_size       = 2'b00;
    m_addr       = 32'h0;
    m_wstrb      = 4'h0;
    m_wdata      = 32'h0;
    if (w_drain) begin
      m_size  = r_fifo_size[r_rd_ptr];
      m_addr  = r_fifo_addr[r_rd_ptr];
      m_wstrb = r_fifo_wstrb[r_rd_ptr];
      m_wdata = r_fifo_wdata[r_rd_ptr];
    end else if (w_load_fwd) begin
      m_size = data_size;
      m_addr = data_addr;
    end
    data_addr_ok = w_store_acc | w_load_acc;
    data_data_ok = (~reset & r_ack_pend) | w_rd_done;
    data_rdata   = w_rd_done ? m_rdata : 32'h0;
  end

  // Store entry payload; no reset needed, validity is tracked by r_cnt
  always_ff @(posedge clk) begin
    if (w_store_acc) begin
      r_fifo_size[r_wr_ptr]  <= data_size;
      r_fifo_addr[r_wr_ptr]  <= data_addr;
      r_fifo_wstrb[r_wr_ptr] <= data_wstrb;
      r_fifo_wdata[r_wr_ptr] <= data_wdata;
    end
  end

  // Pointers, occupancy, outstanding-transaction and ack bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_wr_out   <= '0;
      r_rd_busy  <= 1'b0;
      r_ack_pend <= 1'b0;
    end else begin
      if (w_store_acc) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)       r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_store_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: ;
      endcase
      case ({w_pop, w_wr_done})
        2'b10:   r_wr_out <= r_wr_out + OutW'(1);
        2'b01:   r_wr_out <= r_wr_out - OutW'(1);
        default: ;
      endcase
      r_ack_pend <= w_store_acc;
      if (w_load_acc) begin
        r_rd_busy <= 1'b1;
      end else if (w_rd_done) begin
        r_rd_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Bench for data_store_buffer: a randomized bridge/memory model plus a
// pipeline driver; responses are checked through scoreboard queues.
module tb_data_store_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned OUT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  data_store_buffer #(.DEPTH(DEPTH), .OUT_MAX(OUT_MAX)) dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } wr_t;
  typedef struct {
    bit          wr;
    logic [31:0] data;
  } pend_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_resp [$];          // expected data_rdata per pipeline response
  wr_t         sb_wr   [$];          // stores expected at the bridge, in order
  pend_t       br_pend [$];          // bridge transactions awaiting m_data_ok
  logic [31:0] ref_mem [bit [29:0]]; // memory as the pipeline should see it
  logic [31:0] br_mem  [bit [29:0]]; // memory behind the bridge
  int aok_pct = 100;
  int dok_pct = 100;
  bit spur_en = 1'b0;
  int n_br_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input bit [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] br_rd(input bit [29:0] a);
    return br_mem.exists(a) ? br_mem[a] : 32'h0;
  endfunction

  // Bridge + memory model: random accept/response timing, in-order responses.
  initial begin
    int    pend_before;
    pend_t p;
    wr_t   w;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      m_addr_ok = ($urandom_range(99) < aok_pct);
      if (br_pend.size() > 0) begin
        m_data_ok = ($urandom_range(99) < dok_pct);
        m_rdata   = br_pend[0].wr ? $urandom() : br_pend[0].data;
      end else begin
        m_data_ok = spur_en && ($urandom_range(9) == 0);
        m_rdata   = $urandom();
      end
      #4;
      if (reset) begin
        br_pend.delete();
      end else begin
        pend_before = br_pend.size();
        if (m_data_ok && br_pend.size() > 0) void'(br_pend.pop_front());
        if (m_req && m_addr_ok) begin
          if (m_wr) begin
            n_br_wr++;
            chk("wr_out_limit", 32'(pend_before < OUT_MAX), 32'd1);
            chk("drain_has_store", 32'(sb_wr.size() > 0), 32'd1);
            if (sb_wr.size() > 0) begin
              w = sb_wr.pop_front();
              chk("drain_addr", m_addr, w.addr);
              chk("drain_wdata", m_wdata, w.wdata);
              chk("drain_size_strb", {26'h0, m_size, m_wstrb}, {26'h0, w.size, w.wstrb});
            end
            br_mem[m_addr[31:2]] = merge(br_rd(m_addr[31:2]), m_wdata, m_wstrb);
            p.wr   = 1'b1;
            p.data = 32'h0;
          end else begin
            chk("load_after_stores", 32'(pend_before == 0 && sb_wr.size() == 0), 32'd1);
            chk("load_wstrb", {28'h0, m_wstrb}, 32'h0);
            p.wr   = 1'b0;
            p.data = br_rd(m_addr[31:2]);
          end
          br_pend.push_back(p);
        end
      end
    end
  end

  // Response monitor: every data_data_ok must match the next expected response.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && data_data_ok) begin
        if (sb_resp.size() == 0) chk("unexpected_data_ok", {31'h0, data_data_ok}, 32'h0);
        else chk("resp_rdata", data_rdata, sb_resp.pop_front());
      end
    end
  end

  // One pipeline cycle: drive after negedge, sample just before posedge.
  task automatic cyc(input bit rst, input bit req, input bit wr, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd, output bit acc);
    wr_t w;
    @(negedge clk);
    reset      = rst;
    data_req   = req;
    data_wr    = wr;
    data_size  = 2'd2;
    data_addr  = addr;
    data_wstrb = wr ? strb : 4'h0;
    data_wdata = wd;
    #4;
    acc = 1'b0;
    if (rst) begin
      sb_resp.delete();
      sb_wr.delete();
      ref_mem = br_mem;
    end else if (req && data_addr_ok) begin
      acc = 1'b1;
      if (wr) begin
        ref_mem[addr[31:2]] = merge(ref_rd(addr[31:2]), wd, strb);
        sb_resp.push_back(32'h0);
        w.size  = 2'd2;
        w.addr  = addr;
        w.wstrb = strb;
        w.wdata = wd;
        sb_wr.push_back(w);
      end else begin
        sb_resp.push_back(ref_rd(addr[31:2]));
      end
    end
  endtask

  task automatic idle();
    bit acc;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((sb_resp.size() != 0 || sb_wr.size() != 0 || br_pend.size() != 0) && n < 200) begin
      idle();
      n++;
    end
    chk(name, 32'(sb_resp.size() == 0 && sb_wr.size() == 0 && br_pend.size() == 0), 32'd1);
  endtask

  initial begin
    bit acc;
    int n;
    int snap;
    reset = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wstrb = 4'h0; data_wdata = 32'h0;

    // Reset: all outputs low even with a store presented
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h1000, 4'hF, 32'h55, acc);
      chk("rst_outputs", {28'h0, m_req, data_addr_ok, data_data_ok, |data_rdata}, 32'h0);
    end

    // Single store, bridge always ready
    cyc(1'b0, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, acc);
    chk("s1_addr_ok", {31'h0, acc}, 32'd1);
    chk("s1_no_early_ack", {31'h0, data_data_ok}, 32'h0);
    idle();
    chk("s1_ack_next", {31'h0, data_data_ok}, 32'd1);
    chk("s1_m_req_wr", {30'h0, m_req, m_wr}, 32'h3);
    chk("s1_m_addr", m_addr, 32'h1000);
    chk("s1_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("s1_m_wstrb", {28'h0, m_wstrb}, 32'hF);
    wait_quiet("s1_drained");

    // Five stores against a stalled bridge: fifth refused until a pop
    aok_pct = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), acc);
      chk("s2_accept", {31'h0, acc}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h1010, 4'hF, 32'hA000_0004, acc);
      chk("s2_full_refuse", {31'h0, acc}, 32'h0);
      chk("s2_head_hold", m_addr, 32'h1000);
    end
    aok_pct = 100;
    cyc(1'b0, 1'b1, 1'b1, 32'h1010, 4'hF, 32'hA000_0004, acc);
    chk("s2_pop_cycle_refuse", {31'h0, acc}, 32'h0);
    chk("s2_pop_seen", {31'h0, m_req & m_addr_ok}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h1010, 4'hF, 32'hA000_0004, acc);
    chk("s2_accept_after_pop", {31'h0, acc}, 32'd1);
    wait_quiet("s2_drained");

    // Outstanding-store limit with responses withheld
    dok_pct = 0;
    snap = n_br_wr;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h1100 + 32'(4 * i), 4'h3, 32'hB000_0000 + 32'(i), acc);
      chk("s3_accept", {31'h0, acc}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("s3_out_max_stall", {31'h0, m_req}, 32'h0);
    end
    chk("s3_issued", 32'(n_br_wr - snap), 32'd3);
    dok_pct = 100;
    n = 0;
    while (!m_req && n < 6) begin
      idle();
      n++;
    end
    chk("s3_resume", {31'h0, m_req}, 32'd1);
    wait_quiet("s3_drained");

    // Store then load to the same address
    cyc(1'b0, 1'b1, 1'b1, 32'h2000, 4'hF, 32'h12345678, acc);
    chk("s4_store_acc", {31'h0, acc}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h2000, 4'h0, 32'h0, acc);
    chk("s4_load_held", {31'h0, acc}, 32'h0);
    n = 0;
    while (!acc && n < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h2000, 4'h0, 32'h0, acc);
      n++;
    end
    chk("s4_load_fwd", {31'h0, acc}, 32'd1);
    chk("s4_fwd_fields", {m_addr[31:2], m_req, m_wr}, {30'(32'h2000 >> 2), 2'b10});
    n = 0;
    do begin
      idle();
      n++;
    end while (!data_data_ok && n < 20);
    chk("s4_rdata", data_rdata, 32'h12345678);
    wait_quiet("s4_done");

    // Load outstanding blocks a following store
    dok_pct = 0;
    cyc(1'b0, 1'b1, 1'b0, 32'h2000, 4'h0, 32'h0, acc);
    chk("s5_load_acc", {31'h0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h2004, 4'hF, 32'hC0FFEE00, acc);
      chk("s5_store_held", {31'h0, acc}, 32'h0);
    end
    dok_pct = 100;
    cyc(1'b0, 1'b1, 1'b1, 32'h2004, 4'hF, 32'hC0FFEE00, acc);
    chk("s5_load_resp", {31'h0, data_data_ok}, 32'd1);
    chk("s5_store_still_held", {31'h0, acc}, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h2004, 4'hF, 32'hC0FFEE00, acc);
    chk("s5_store_after", {31'h0, acc}, 32'd1);
    wait_quiet("s5_drained");

    // Reset with stores buffered and in flight
    dok_pct = 0;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 32'h1200 + 32'(4 * i), 4'hF, 32'h1, acc);
    idle();
    aok_pct = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 32'h1210 + 32'(4 * i), 4'hF, 32'h2, acc);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
    chk("s6_rst_outputs", {30'h0, m_req, data_data_ok}, 32'h0);
    aok_pct = 100;
    dok_pct = 100;
    idle();
    chk("s6_post_rst_idle", {30'h0, m_req, data_data_ok}, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, acc);
    chk("s6_addr_ok", {31'h0, acc}, 32'd1);
    idle();
    chk("s6_ack_next", {31'h0, data_data_ok}, 32'd1);
    chk("s6_m_addr", m_addr, 32'h1000);
    wait_quiet("s6_drained");

    // Randomized mixed traffic with random bridge timing
    spur_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wd;
      if (t % 50 == 0) begin
        aok_pct = $urandom_range(100, 20);
        dok_pct = $urandom_range(100, 20);
      end
      wr   = 1'($urandom_range(1));
      addr = 32'h3000 + 32'(4 * $urandom_range(7));
      strb = 4'($urandom_range(15, 1));
      wd   = $urandom();
      n    = 0;
      acc  = 1'b0;
      while (!acc && n < 200) begin
        cyc(1'b0, 1'b1, wr, addr, strb, wd, acc);
        n++;
      end
      if (!acc) chk("rand_accept_timeout", {31'h0, acc}, 32'd1);
      for (int k = $urandom_range(2); k > 0; k--) idle();
    end
    spur_en = 1'b0;
    wait_quiet("rand_drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
